fft_input_framer: RTL and testbench

//   Upstream feeder for the 16-point bit-reversal stage. Accepts a complex sample stream over a

---
 rtl/fft_input_framer.sv | 92 +++++++++
 tb/tb_fft_input_framer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// fft_input_framer: packs a valid/ready complex sample stream into one
// N_POINTS-wide real/imag frame for the bit-reversal stage, launches it with a
// one-cycle start_reorder pulse and holds it until the consumer reports done.
//
// state  | meaning
// IDLE   | first cycle after reset release, raises s_ready
// FILL   | accepting samples into slot cnt
// LAUNCH | frame complete, start_reorder high this cycle
// WAIT   | frame held stable, stream backpressured until reorder_done
module fft_input_framer #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  parameter int LOG2N    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_W-1:0]     s_real,
  input  logic signed [DATA_W-1:0]     s_imag,
  input  logic                         s_last,
  output logic [N_POINTS*DATA_W-1:0]   real_out,
  output logic [N_POINTS*DATA_W-1:0]   imag_out,
  output logic                         start_reorder,
  input  logic                         reorder_done,
  output logic                         frame_padded,
  output logic [7:0]                   frame_count
);

  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, WAIT} state_t;

  localparam logic [LOG2N-1:0] LAST_SLOT = LOG2N'(N_POINTS - 1);

  state_t           state;
  logic [LOG2N-1:0] cnt;

  // Framing FSM; every output is registered so the consumer sees clean levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      s_ready       <= 1'b0;
      start_reorder <= 1'b0;
      real_out      <= '0;
      imag_out      <= '0;
      frame_padded  <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      start_reorder <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          state   <= FILL;
        end
        FILL: begin
          if (s_valid && s_ready) begin
            real_out[int'(cnt)*DATA_W +: DATA_W] <= s_real;
            imag_out[int'(cnt)*DATA_W +: DATA_W] <= s_imag;
            cnt <= cnt + 1'b1;
            if ((cnt == LAST_SLOT) || s_last) begin
              // Zero the slots above the closing sample so a short frame
              // never carries data from an earlier frame.
              for (int k = 0; k < N_POINTS; k++) begin
                if (k > int'(cnt)) begin
                  real_out[k*DATA_W +: DATA_W] <= '0;
                  imag_out[k*DATA_W +: DATA_W] <= '0;
                end
              end
              frame_padded  <= (cnt != LAST_SLOT);
              s_ready       <= 1'b0;
              start_reorder <= 1'b1;
              frame_count   <= frame_count + 1'b1;
              state         <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          if (reorder_done) begin
            cnt     <= '0;
            s_ready <= 1'b1;
            state   <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: directed and random streams checked every cycle
// against a frame-level reference model.
module tb_fft_input_framer;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int FW = N * DW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_real = '0;
  logic signed [DW-1:0] s_imag = '0;
  logic                 s_last = 1'b0;
  logic [FW-1:0]        real_out;
  logic [FW-1:0]        imag_out;
  logic                 start_reorder;
  logic                 reorder_done = 1'b0;
  logic                 frame_padded;
  logic [7:0]           frame_count;

  fft_input_framer #(.N_POINTS(N), .DATA_W(DW), .LOG2N(4)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .real_out(real_out), .imag_out(imag_out), .start_reorder(start_reorder),
    .reorder_done(reorder_done), .frame_padded(frame_padded),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: a frame image plus a few flags describing where the
  // framer is in its fill / launch / wait sequence.
  logic [FW-1:0] m_real, m_imag;
  int   m_cnt, m_frames, m_launches, m_accepts;
  bit   m_idle, m_ready, m_start, m_wait, m_padded;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_real = '0; m_imag = '0; m_cnt = 0; m_frames = 0;
    m_idle = 1; m_ready = 0; m_start = 0; m_wait = 0; m_padded = 0;
  endtask

  task automatic model_edge(input bit v, input bit last, input logic [DW-1:0] re,
                            input logic [DW-1:0] im, input bit done);
    if (m_idle) begin
      m_idle = 0; m_ready = 1;
    end else if (m_start) begin
      m_start = 0; m_wait = 1;
    end else if (m_wait) begin
      if (done) begin m_wait = 0; m_ready = 1; m_cnt = 0; end
    end else if (v && m_ready) begin
      m_real[m_cnt*DW +: DW] = re;
      m_imag[m_cnt*DW +: DW] = im;
      m_cnt++;
      m_accepts++;
      if (m_cnt == N || last) begin
        for (int k = m_cnt; k < N; k++) begin
          m_real[k*DW +: DW] = '0;
          m_imag[k*DW +: DW] = '0;
        end
        m_padded = (m_cnt < N);
        m_ready = 0;
        m_start = 1;
        m_frames = (m_frames + 1) % 256;
        m_launches++;
      end
    end
  endtask

  task automatic check_all();
    check("s_ready", FW'(s_ready), FW'(m_ready));
    check("start_reorder", FW'(start_reorder), FW'(m_start));
    check("frame_padded", FW'(frame_padded), FW'(m_padded));
    check("frame_count", FW'(frame_count), FW'(m_frames));
    check("real_out", real_out, m_real);
    check("imag_out", imag_out, m_imag);
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cyc(input bit v, input bit last, input logic [DW-1:0] re,
                     input logic [DW-1:0] im, input bit done);
    s_valid = v; s_last = last; s_real = re; s_imag = im; reorder_done = done;
    @(posedge clk);
    model_edge(v, last, re, im, done);
    #1;
    check_all();
  endtask

  // Let a closed frame launch, wait a few cycles, then return done.
  task automatic finish_frame(input int hold);
    for (int i = 0; i < hold; i++) cyc(0, 0, '0, '0, 0);
    cyc(0, 0, '0, '0, 1);
  endtask

  initial begin
    int acc0, launch0, guard;
    logic [FW-1:0] held_real;
    logic [7:0] fc0;
    m_launches = 0; m_accepts = 0;
    model_reset();

    // Reset state
    #2;
    check_all();
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(0, 0, '0, '0, 0);

    // Full frame real=0..15, imag=0, valid held high
    for (int k = 0; k < N; k++) cyc(1, 0, DW'(k), '0, 0);
    check("accepts_full", FW'(m_accepts), FW'(16));

    // Backpressure: valid stays high through launch and wait, done 5 cycles after start
    held_real = m_real;
    acc0 = m_accepts;
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h7777, 16'h1111, 0);
    check("real_held", real_out, held_real);
    check("no_accept_wait", FW'(m_accepts - acc0), FW'(0));
    cyc(1, 0, 16'h7777, 16'h1111, 1);
    cyc(1, 0, 16'h0042, 16'h0043, 0);
    check("accept_after_done", FW'(m_accepts - acc0), FW'(1));
    for (int k = 1; k < N; k++) cyc(1, 0, DW'($urandom), DW'($urandom), 0);
    finish_frame(3);

    // Early close after 5 samples
    launch0 = m_launches;
    for (int k = 0; k < 5; k++) cyc(1, k == 4, DW'(100 + k), DW'($urandom), 0);
    s_valid = 0; s_last = 0;
    finish_frame(2);
    check("early_launches", FW'(m_launches - launch0), FW'(1));

    // s_last without valid is ignored, then gapped signed extremes
    acc0 = m_accepts;
    cyc(0, 1, 16'h1234, 16'h1234, 0);
    for (int i = 0; i < 2 * N; i++)
      cyc(i % 2 == 0, 0, (i % 4 == 0) ? 16'h8000 : 16'h7fff,
          (i % 4 == 0) ? 16'h7fff : 16'h8000, 0);
    check("gapped_accepts", FW'(m_accepts - acc0), FW'(16));
    finish_frame(2);

    // Async reset after the 9th accept
    for (int k = 0; k < 9; k++) cyc(1, 0, DW'($urandom), DW'($urandom), 0);
    s_valid = 0;
    #3 reset = 1'b0;
    #1 model_reset();
    check_all();
    #2 reset = 1'b1;
    cyc(0, 0, '0, '0, 0);
    cyc(1, 0, 16'h0abc, 16'h0def, 0);
    check("slot0_after_reset", FW'(real_out[DW-1:0]), FW'(16'h0abc));
    for (int k = 1; k < N; k++) cyc(1, 0, DW'($urandom), DW'($urandom), 0);
    finish_frame(1);

    // Wrap: 256 random frames with done held high
    fc0 = 8'(m_frames);
    launch0 = m_launches;
    guard = 0;
    while ((m_launches - launch0) < 256 && guard < 20000) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          DW'($urandom), DW'($urandom), 1);
      guard++;
    end
    check("wrap_launches", FW'(m_launches - launch0), FW'(256));
    check("wrap_count", FW'(frame_count), FW'(fc0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
